// File: rtl/multicycle_control_pkg.sv
// Shared encodings for the multicycle controller and its datapath.
// Opcodes, FSM states and datapath mux/ALU selects live here so both sides agree.
package multicycle_control_pkg;

    typedef enum logic [5:0] {
        OP_ADD  = 6'b000001,
        OP_SUB  = 6'b000010,
        OP_AND  = 6'b000011,
        OP_OR   = 6'b000100,
        OP_ADDI = 6'b000101,
        OP_ANDI = 6'b000110,
        OP_LW   = 6'b000111,
        OP_SW   = 6'b001000,
        OP_LI   = 6'b001001,
        OP_BNE  = 6'b001010,
        OP_J    = 6'b001011,
        OP_HALT = 6'b111111
    } opcode_e;

    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_FETCH  = 4'd1,
        S_DECODE = 4'd2,
        S_EXEC_R = 4'd3,
        S_EXEC_I = 4'd4,
        S_MEM_RD = 4'd5,
        S_MEM_WR = 4'd6,
        S_WB_ALU = 4'd7,
        S_WB_MEM = 4'd8,
        S_WB_IMM = 4'd9,
        S_BRANCH = 4'd10,
        S_JUMP   = 4'd11,
        S_HALT   = 4'd12
    } state_e;

    typedef enum logic [3:0] {
        ALU_ADD = 4'b0000,
        ALU_SUB = 4'b0001,
        ALU_AND = 4'b0010,
        ALU_OR  = 4'b0011
    } aluop_e;

    typedef enum logic [1:0] {
        SRCB_REGB = 2'd0,
        SRCB_ONE  = 2'd1,
        SRCB_SEXT = 2'd2,
        SRCB_ZEXT = 2'd3
    } alusrcb_e;

    typedef enum logic [1:0] {
        M2R_ALUOUT = 2'd0,
        M2R_MDR    = 2'd1,
        M2R_IMM    = 2'd2
    } memtoreg_e;

    typedef enum logic [1:0] {
        PC_ALURESULT = 2'd0,
        PC_ALUOUT    = 2'd1,
        PC_JUMP      = 2'd2
    } pcsource_e;

    typedef struct packed {
        logic      pcWriteCond;
        logic      pcWrite;
        logic      memRead;
        logic      memWrite;
        logic      irWrite;
        logic      aluSrcA;
        logic      regWrite;
        logic      regDst;
        memtoreg_e memtoReg;
        aluop_e    aluOp;
        alusrcb_e  aluSrcB;
        pcsource_e pcSource;
    } ctrl_t;

    function automatic logic isRType(input logic [5:0] op);
        case (op)
            OP_ADD, OP_SUB, OP_AND, OP_OR: return 1'b1;
            default:                       return 1'b0;
        endcase
    endfunction

    function automatic logic isLegalOp(input logic [5:0] op);
        case (op)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ADDI, OP_ANDI,
            OP_LW, OP_SW, OP_LI, OP_BNE, OP_J, OP_HALT: return 1'b1;
            default:                                    return 1'b0;
        endcase
    endfunction

    // Last state of an instruction; leaving it retires that instruction.
    function automatic logic isTerminal(input state_e s);
        case (s)
            S_WB_ALU, S_WB_MEM, S_WB_IMM, S_MEM_WR, S_BRANCH, S_JUMP: return 1'b1;
            default:                                                   return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/multicycle_control_if.sv
// Controller <-> datapath bundle: instruction inputs, datapath controls and status.
interface multicycle_control_if;
    logic       start;
    logic [5:0] opcode;
    logic       PCWriteCond;
    logic       PCWrite;
    logic       MemRead;
    logic       MemWrite;
    logic       IRWrite;
    logic       ALUSrcA;
    logic       RegWrite;
    logic       RegDst;
    logic [1:0] MemtoReg;
    logic [3:0] ALUOp;
    logic [1:0] ALUSrcB;
    logic [1:0] PCSource;
    logic [3:0] state;
    logic       halted;
    logic       illegal;
    logic [15:0] retired;

    modport master (
        input  start, opcode,
        output PCWriteCond, PCWrite, MemRead, MemWrite, IRWrite, ALUSrcA,
               RegWrite, RegDst, MemtoReg, ALUOp, ALUSrcB, PCSource,
               state, halted, illegal, retired
    );

    modport slave (
        output start, opcode,
        input  PCWriteCond, PCWrite, MemRead, MemWrite, IRWrite, ALUSrcA,
               RegWrite, RegDst, MemtoReg, ALUOp, ALUSrcB, PCSource,
               state, halted, illegal, retired
    );
endinterface

// File: rtl/multicycle_control_retire_counter.sv
// 16-bit retired-instruction counter; wraps naturally, async active-low clear.
module retire_counter (
    input  logic        clk,
    input  logic        clrN,
    input  logic        en,
    output logic [15:0] count
);
    always_ff @(posedge clk or negedge clrN) begin
        if (!clrN)   count <= '0;
        else if (en) count <= count + 16'd1;
    end
endmodule

// File: rtl/multicycle_control.sv
// Multicycle CPU control FSM: Moore decode of state+opcode into datapath controls,
// sticky illegal-opcode flag and retired-instruction count.
module multicycle_control
    import multicycle_control_pkg::*;
(
    input logic                  clk,
    input logic                  reset,
    multicycle_control_if.master bus
);
    state_e      state, nextState;
    logic        illegalQ;
    logic        retireEn;
    logic [15:0] retiredCnt;
    logic [5:0]  op;
    ctrl_t       ctrl;

    assign op = bus.opcode;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= S_IDLE;
            illegalQ <= 1'b0;
        end else begin
            state <= nextState;
            if (state == S_DECODE && !isLegalOp(op)) illegalQ <= 1'b1;
        end
    end

    always_comb begin
        nextState = state;
        case (state)
            S_IDLE:   if (bus.start) nextState = S_FETCH;
            S_FETCH:  nextState = S_DECODE;
            S_DECODE: begin
                case (op)
                    OP_ADD, OP_SUB, OP_AND, OP_OR: nextState = S_EXEC_R;
                    OP_ADDI, OP_ANDI:              nextState = S_EXEC_I;
                    OP_LW:                         nextState = S_MEM_RD;
                    OP_SW:                         nextState = S_MEM_WR;
                    OP_LI:                         nextState = S_WB_IMM;
                    OP_BNE:                        nextState = S_BRANCH;
                    OP_J:                          nextState = S_JUMP;
                    OP_HALT:                       nextState = S_HALT;
                    default:                       nextState = S_FETCH;
                endcase
            end
            S_EXEC_R, S_EXEC_I: nextState = S_WB_ALU;
            S_MEM_RD:           nextState = S_WB_MEM;
            S_WB_ALU, S_WB_MEM, S_WB_IMM, S_MEM_WR, S_BRANCH, S_JUMP:
                                nextState = S_FETCH;
            S_HALT:             nextState = S_HALT;
            // Unused encodings fall back to IDLE rather than locking up.
            default:            nextState = S_IDLE;
        endcase
    end

    always_comb begin
        ctrl = '0;
        case (state)
            S_FETCH: begin
                ctrl.memRead  = 1'b1;
                ctrl.irWrite  = 1'b1;
                ctrl.aluSrcB  = SRCB_ONE;
                ctrl.aluOp    = ALU_ADD;
                ctrl.pcSource = PC_ALURESULT;
                ctrl.pcWrite  = 1'b1;
            end
            S_DECODE: begin
                // Precompute the branch target into ALUOut while registers are read.
                ctrl.aluSrcB = SRCB_SEXT;
                ctrl.aluOp   = ALU_ADD;
                ctrl.regDst  = isRType(op) || (op == OP_BNE);
            end
            S_EXEC_R: begin
                ctrl.aluSrcA = 1'b1;
                ctrl.aluSrcB = SRCB_REGB;
                ctrl.regDst  = 1'b1;
                case (op)
                    OP_SUB:  ctrl.aluOp = ALU_SUB;
                    OP_AND:  ctrl.aluOp = ALU_AND;
                    OP_OR:   ctrl.aluOp = ALU_OR;
                    default: ctrl.aluOp = ALU_ADD;
                endcase
            end
            S_EXEC_I: begin
                ctrl.aluSrcA = 1'b1;
                if (op == OP_ANDI) begin
                    ctrl.aluSrcB = SRCB_ZEXT;
                    ctrl.aluOp   = ALU_AND;
                end else begin
                    ctrl.aluSrcB = SRCB_SEXT;
                    ctrl.aluOp   = ALU_ADD;
                end
            end
            S_MEM_RD: ctrl.memRead = 1'b1;
            S_MEM_WR: ctrl.memWrite = 1'b1;
            S_WB_ALU: begin
                ctrl.regWrite = 1'b1;
                ctrl.memtoReg = M2R_ALUOUT;
            end
            S_WB_MEM: begin
                ctrl.regWrite = 1'b1;
                ctrl.memtoReg = M2R_MDR;
            end
            S_WB_IMM: begin
                ctrl.regWrite = 1'b1;
                ctrl.memtoReg = M2R_IMM;
            end
            S_BRANCH: begin
                ctrl.aluSrcA     = 1'b1;
                ctrl.aluSrcB     = SRCB_REGB;
                ctrl.regDst      = 1'b1;
                ctrl.aluOp       = ALU_SUB;
                ctrl.pcWriteCond = 1'b1;
                ctrl.pcSource    = PC_ALUOUT;
            end
            S_JUMP: begin
                ctrl.pcWrite  = 1'b1;
                ctrl.pcSource = PC_JUMP;
            end
            default: ctrl = '0;
        endcase
    end

    // Illegal-opcode returns to FETCH leave from DECODE, so they never count.
    assign retireEn = (isTerminal(state) && nextState == S_FETCH) ||
                      (state != S_HALT && nextState == S_HALT);

    retire_counter uRetire (
        .clk   (clk),
        .clrN  (reset),
        .en    (retireEn),
        .count (retiredCnt)
    );

    assign bus.PCWriteCond = ctrl.pcWriteCond;
    assign bus.PCWrite     = ctrl.pcWrite;
    assign bus.MemRead     = ctrl.memRead;
    assign bus.MemWrite    = ctrl.memWrite;
    assign bus.IRWrite     = ctrl.irWrite;
    assign bus.ALUSrcA     = ctrl.aluSrcA;
    assign bus.RegWrite    = ctrl.regWrite;
    assign bus.RegDst      = ctrl.regDst;
    assign bus.MemtoReg    = ctrl.memtoReg;
    assign bus.ALUOp       = ctrl.aluOp;
    assign bus.ALUSrcB     = ctrl.aluSrcB;
    assign bus.PCSource    = ctrl.pcSource;
    assign bus.state       = state;
    assign bus.halted      = (state == S_HALT);
    assign bus.illegal     = illegalQ;
    assign bus.retired     = retiredCnt;

endmodule
